// File: rtl/demux_1x3_buf.sv
// demux_1x3_buf: routes one input stream into three independent FIFOs; select 11 discards.
// Optional macro DEMUX_DROP_CNT_EN adds a saturating drop_cnt output.
module demux_1x3_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
`ifdef DEMUX_DROP_CNT_EN
  output logic [15:0]      drop_cnt,
`endif
  output logic [WIDTH-1:0] out3_data,
  output logic             out3_valid,
  input  logic             out3_ready
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0] full;
  logic [2:0] vld, rdy;
  logic [WIDTH-1:0] head [3];
  logic acc;
  // full[3] stands for the discard path, which can always accept
  assign full[3] = 1'b0;
  assign in_ready = rst_n & ~full[select];
  assign acc = in_valid & in_ready;
  assign rdy = {out3_ready, out2_ready, out1_ready};
  assign out1_data = head[0];
  assign out2_data = head[1];
  assign out3_data = head[2];
  assign out1_valid = vld[0];
  assign out2_valid = vld[1];
  assign out3_valid = vld[2];
  for (genvar i = 0; i < 3; i++) begin : g_fifo
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] cnt;
    logic push, pop;
    assign push = acc & (select == 2'(i));
    assign pop = vld[i] & rdy[i];
    assign vld[i] = cnt != '0;
    assign full[i] = cnt == (AW+1)'(DEPTH);
    assign head[i] = vld[i] ? mem[rptr] : '0;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wptr <= '0;
        rptr <= '0;
        cnt <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
    always_ff @(posedge clk)
      if (push) mem[wptr] <= in_data;
  end
`ifdef DEMUX_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (acc && select == 2'b11 && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
`endif
endmodule

// File: doc/demux_1x3_buf.md
DEMUX_1X3_BUF -- requirements
Module: demux_1x3_buf

Interface
REQ-001 Parameter WIDTH, default 32, data width of the input and each output port.
REQ-002 Parameter DEPTH, default 2, entries per output FIFO; power of two, at least 2.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  word to route.
REQ-006 select  input  2  destination: 00 to out1, 01 to out2, 10 to out3, 11 to discard.
REQ-007 in_valid  input  1  in_data and select are valid.
REQ-008 in_ready  output  1  block accepts the word this cycle.
REQ-009 outN_data  output  WIDTH  head word of FIFO N, for N = 1..3.
REQ-010 outN_valid  output  1  FIFO N is non-empty.
REQ-011 outN_ready  input  1  consumer N takes the head word this cycle.
REQ-012 drop_cnt  output  16  count of discarded words; present only under DEMUX_DROP_CNT_EN.

Function
REQ-013 Accept shall occur when in_valid=1 and in_ready=1 on a rising edge.
REQ-014 in_ready shall be combinational: 1 when select=11, otherwise not(full of the selected FIFO).
REQ-015 in_ready shall not depend on outN_ready, so a full FIFO never accepts, even if it is popped in the same cycle.
REQ-016 An accepted word with select 00/01/10 shall be pushed into FIFO 1/2/3 respectively.
REQ-017 An accepted word with select 11 shall be discarded and leave no FIFO state change.
REQ-018 Latency: a word pushed at edge k into an empty FIFO shall appear on outN_data with outN_valid=1 after edge k.
REQ-019 Pop of FIFO N shall occur on the edge where outN_valid=1 and outN_ready=1.
REQ-020 outN_data shall stay stable while outN_valid=1 and outN_ready=0.
REQ-021 Each FIFO shall preserve arrival order.
REQ-022 Each FIFO shall track occupancy 0..DEPTH using wrap-around read and write pointers.
REQ-023 Simultaneous push and pop on the same non-full FIFO shall leave occupancy unchanged.
REQ-024 Pop on empty and push on full shall never occur; the handshake rules prevent both.
REQ-025 The three FIFOs shall operate independently; a full FIFO shall not stall traffic selected to another destination.
REQ-026 in_valid=1 with in_ready=0 shall change no state; the source holds in_data and select.

Reset
REQ-027 While rst_n=0, immediately and independent of clk: all FIFOs empty, pointers 0, outN_valid=0, outN_data=0, drop_cnt=0, in_ready=0.
REQ-028 Reset asserted mid-transfer shall discard all buffered words with no partial output.
REQ-029 The first accept is possible on the first rising edge after rst_n rises.

Configuration
REQ-030 Macro DEMUX_DROP_CNT_EN defined: drop_cnt shall increment by 1 on each accepted select=11 word.
REQ-031 drop_cnt shall saturate at 16'hFFFF.
REQ-032 Macro DEMUX_DROP_CNT_EN undefined: port drop_cnt and its register shall be absent; routing behaviour is identical in both builds.

Verification
REQ-033 Route test: after reset, send 5/sel 00, 9/sel 01, 12/sel 10, all outN_ready=1 -> out1=5, out2=9, out3=12, each valid for exactly one cycle, one cycle after its accept.
REQ-034 Backpressure test: out2_ready=0, send 1, 2, 3 with sel 01 -> first two accepted; in_ready=0 on the third; out2_data=1 held; raise out2_ready -> 1, 2, 3 delivered in order.
REQ-035 Independence test: FIFO 1 full with out1_ready=0, send 7/sel 10 -> in_ready=1 and out3_data=7 next cycle.
REQ-036 Discard test: send 3 words with sel 11 -> in_ready=1, no outN_valid asserted, drop_cnt=3 when the macro is defined; separately, 65537 drops -> drop_cnt=16'hFFFF.
REQ-037 Reset test: FIFO 1 holds 2 words, pulse rst_n low between edges -> out1_valid=0 and out1_data=0 immediately; no stale word after release.
REQ-038 Concurrency test: FIFO 2 holds 1 word, push and pop FIFO 2 on the same edge -> occupancy stays 1 and the new word appears next.
